// File: rtl/branch_resolve_ctrl_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl_if
// Bundles the fetch-side push signals, the EX-side resolve signals and all
// controller outputs (predictor update, flush/redirect, statistics, debug).
//
// Handshake semantics (the only handshake on this bus):
//   A branch is pushed in a cycle where if_valid=1, if_opcode is a
//   conditional branch, stall=0 and push_ready=1, all sampled at the same
//   rising clk edge. push_ready is combinational and may depend on
//   ex_resolve in the same cycle. The producer must hold the fetch (stall
//   upstream) while push_ready=0. ex_resolve has no ready; it is always
//   consumed at the clock edge.
//
// Modports:
//   master : pipeline side (drives IF/EX inputs, observes outputs)
//   slave  : the branch_resolve_ctrl block
// ----------------------------------------------------------------------------
interface branch_resolve_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  // IF stage
  logic            if_valid;
  logic [6:0]      if_opcode;
  logic            if_prediction;
  logic [PC_W-1:0] if_pc_plus4;
  logic            stall;
  logic            push_ready;
  // EX stage
  logic            ex_resolve;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  // Predictor update / recovery
  logic             bp_enable;
  logic [1:0]       bp_outcome;
  logic             flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  // Statistics and status
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             protocol_err;
  // Debug: controller FSM state (0 = RUN, 1 = FLUSH)
  logic             dbg_state;

  modport master (
    output if_valid, if_opcode, if_prediction, if_pc_plus4, stall,
    output ex_resolve, ex_taken, ex_target,
    input  push_ready, bp_enable, bp_outcome, flush, redirect_valid,
    input  redirect_pc, branch_count, mispredict_count, protocol_err,
    input  dbg_state
  );

  modport slave (
    input  if_valid, if_opcode, if_prediction, if_pc_plus4, stall,
    input  ex_resolve, ex_taken, ex_target,
    output push_ready, bp_enable, bp_outcome, flush, redirect_valid,
    output redirect_pc, branch_count, mispredict_count, protocol_err,
    output dbg_state
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// branch_resolve_ctrl
// Tracks conditional-branch predictions from IF in an in-order queue, retires
// them when EX resolves the oldest one, drives the 2-bit predictor update,
// raises flush + PC redirect on a mispredict and keeps saturating counters.
//
// Ports:
//   clk   : system clock, rising edge
//   Reset : synchronous, active-high reset
//   bus   : branch_resolve_ctrl_if.slave (IF push, EX resolve, outputs)
// ----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int PC_W      = 32,
  parameter int DEPTH     = 2,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  branch_resolve_ctrl_if.slave  bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int FC_W = $clog2(FLUSH_CYC + 1);
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             pred_mem_q [DEPTH];
  logic             pred_mem_d [DEPTH];
  logic [PC_W-1:0]  pc_mem_q   [DEPTH];
  logic [PC_W-1:0]  pc_mem_d   [DEPTH];
  logic             bp_enable_q, bp_enable_d;
  logic [1:0]       bp_outcome_q, bp_outcome_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q, branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;
  logic             protocol_err_q, protocol_err_d;

  logic            empty, full, in_run, is_branch, pop, mispredict, push;
  logic            head_pred;
  logic [PC_W-1:0] head_pc;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_run    = (state_q == ST_RUN);
  assign is_branch = bus.if_valid && (bus.if_opcode == OPC_BRANCH);
  assign head_pred = pred_mem_q[rd_ptr_q[AW-1:0]];
  assign head_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
  assign pop       = in_run && bus.ex_resolve && !empty;
  assign mispredict = pop && (head_pred != bus.ex_taken);
  // A push alongside a mispredict is wrong-path and is dropped; when full it
  // needs the same-cycle pop to free the slot.
  assign push      = in_run && is_branch && !bus.stall && !mispredict &&
                     (!full || pop);

  always_comb begin
    state_d            = state_q;
    flush_cnt_d        = flush_cnt_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    pred_mem_d         = pred_mem_q;
    pc_mem_d           = pc_mem_q;
    bp_enable_d        = 1'b0;
    bp_outcome_d       = 2'b00;
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = '0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    protocol_err_d     = protocol_err_q;

    if (push) begin
      pred_mem_d[wr_ptr_q[AW-1:0]] = bus.if_prediction;
      pc_mem_d[wr_ptr_q[AW-1:0]]   = bus.if_pc_plus4;
      wr_ptr_d                     = wr_ptr_q + (AW+1)'(1);
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + (AW+1)'(1);
      bp_enable_d  = 1'b1;
      bp_outcome_d = bus.ex_taken ? 2'b10 : 2'b01;
      if (branch_count_q != '1) branch_count_d = branch_count_q + CNT_W'(1);
    end

    // Everything younger than a mispredicted branch is wrong-path: empty the
    // queue outright (overrides the pointer moves above).
    if (mispredict) begin
      wr_ptr_d         = '0;
      rd_ptr_d         = '0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = bus.ex_taken ? bus.ex_target : head_pc;
      if (mispredict_count_q != '1)
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    if (in_run && bus.ex_resolve && empty) protocol_err_d = 1'b1;

    // flush_cnt holds the number of flush cycles left after the current one.
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = FC_W'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_RUN;
        else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q            <= ST_RUN;
      flush_cnt_q        <= '0;
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pred_mem_q[i] <= 1'b0;
        pc_mem_q[i]   <= '0;
      end
      bp_enable_q        <= 1'b0;
      bp_outcome_q       <= 2'b00;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      protocol_err_q     <= 1'b0;
    end else begin
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      pred_mem_q         <= pred_mem_d;
      pc_mem_q           <= pc_mem_d;
      bp_enable_q        <= bp_enable_d;
      bp_outcome_q       <= bp_outcome_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      protocol_err_q     <= protocol_err_d;
    end
  end

  assign bus.push_ready       = in_run && (!full || bus.ex_resolve);
  assign bus.bp_enable        = bp_enable_q;
  assign bus.bp_outcome       = bp_outcome_q;
  assign bus.flush            = (state_q == ST_FLUSH);
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
  assign bus.protocol_err     = protocol_err_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Directed scenarios with constant expectations, then randomized traffic
// checked against a queue-based reference model of the branch controller.
// ----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;
  localparam int PC_W      = 32;
  localparam int DEPTH     = 2;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 16;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam int unsigned MAXC = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  branch_resolve_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(
    .PC_W(PC_W), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid      = 1'b0;
    bus.if_opcode     = 7'd0;
    bus.if_prediction = 1'b0;
    bus.if_pc_plus4   = '0;
    bus.stall         = 1'b0;
    bus.ex_resolve    = 1'b0;
    bus.ex_taken      = 1'b0;
    bus.ex_target     = '0;
  endtask

  task automatic apply_reset(input int n);
    Reset = 1'b1;
    idle();
    repeat (n) tick();
    Reset = 1'b0;
  endtask

  task automatic set_push(input logic pred, input logic [PC_W-1:0] pc);
    bus.if_valid      = 1'b1;
    bus.if_opcode     = OPC_BR;
    bus.if_prediction = pred;
    bus.if_pc_plus4   = pc;
  endtask

  task automatic set_resolve(input logic taken, input logic [PC_W-1:0] tgt);
    bus.ex_resolve = 1'b1;
    bus.ex_taken   = taken;
    bus.ex_target  = tgt;
  endtask

  task automatic push_br(input logic pred, input logic [PC_W-1:0] pc);
    set_push(pred, pc);
    tick();
    idle();
  endtask

  task automatic resolve(input logic taken, input logic [PC_W-1:0] tgt);
    set_resolve(taken, tgt);
    tick();
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset(2);
    #1;
    n_cmp++; if (bus.push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready: got %0b want 1", bus.push_ready); end
    n_cmp++; if (bus.bp_enable !== 1'b0) begin n_err++; $display("FAIL reset_bp_enable: got %0b want 0", bus.bp_enable); end
    n_cmp++; if (bus.bp_outcome !== 2'b00) begin n_err++; $display("FAIL reset_bp_outcome: got %b want 00", bus.bp_outcome); end
    n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %0b want 0", bus.flush); end
    n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== '0) begin n_err++; $display("FAIL reset_redirect: got %0b/%h want 0/0", bus.redirect_valid, bus.redirect_pc); end
    n_cmp++; if (bus.branch_count !== '0 || bus.mispredict_count !== '0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.branch_count, bus.mispredict_count); end
    n_cmp++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL reset_protocol_err: got %0b want 0", bus.protocol_err); end
  endtask

  task automatic test_correct_predict();
    apply_reset(2);
    push_br(1'b1, 32'h100);
    resolve(1'b1, 32'h300);
    n_cmp++; if (bus.bp_enable !== 1'b1 || bus.bp_outcome !== 2'b10) begin n_err++; $display("FAIL correct_update: got %0b/%b want 1/10", bus.bp_enable, bus.bp_outcome); end
    n_cmp++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL correct_no_flush: got %0b/%0b want 0/0", bus.flush, bus.redirect_valid); end
    n_cmp++; if (bus.branch_count !== CNT_W'(1) || bus.mispredict_count !== '0) begin n_err++; $display("FAIL correct_counts: got %0d/%0d want 1/0", bus.branch_count, bus.mispredict_count); end
    tick();
    n_cmp++; if (bus.bp_enable !== 1'b0 || bus.bp_outcome !== 2'b00) begin n_err++; $display("FAIL correct_strobe_len: got %0b/%b want 0/00", bus.bp_enable, bus.bp_outcome); end
  endtask

  task automatic test_mispredict();
    apply_reset(2);
    push_br(1'b1, 32'h104);
    resolve(1'b0, 32'h900);
    n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h104) begin n_err++; $display("FAIL misp_redirect: got %0b/%h want 1/00000104", bus.redirect_valid, bus.redirect_pc); end
    n_cmp++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL misp_flush_c1: got %0b want 1", bus.flush); end
    n_cmp++; if (bus.bp_enable !== 1'b1 || bus.bp_outcome !== 2'b01) begin n_err++; $display("FAIL misp_update: got %0b/%b want 1/01", bus.bp_enable, bus.bp_outcome); end
    n_cmp++; if (bus.mispredict_count !== CNT_W'(1) || bus.branch_count !== CNT_W'(1)) begin n_err++; $display("FAIL misp_counts: got %0d/%0d want 1/1", bus.branch_count, bus.mispredict_count); end
    n_cmp++; if (bus.push_ready !== 1'b0) begin n_err++; $display("FAIL misp_push_ready: got %0b want 0", bus.push_ready); end
    tick();
    n_cmp++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL misp_flush_c2: got %0b/%0b want 1/0", bus.flush, bus.redirect_valid); end
    tick();
    n_cmp++; if (bus.flush !== 1'b0 || bus.push_ready !== 1'b1) begin n_err++; $display("FAIL misp_flush_end: got %0b/%0b want 0/1", bus.flush, bus.push_ready); end
  endtask

  task automatic test_full();
    apply_reset(2);
    push_br(1'b1, 32'h10);
    push_br(1'b1, 32'h20);
    #1;
    n_cmp++; if (bus.push_ready !== 1'b0) begin n_err++; $display("FAIL full_push_ready: got %0b want 0", bus.push_ready); end
    push_br(1'b0, 32'h30);  // must be dropped
    // push + correct pop while full
    set_push(1'b1, 32'h44);
    set_resolve(1'b1, 32'h0);
    #1;
    n_cmp++; if (bus.push_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready: got %0b want 1", bus.push_ready); end
    tick();
    idle();
    n_cmp++; if (bus.bp_enable !== 1'b1 || bus.branch_count !== CNT_W'(1) || bus.flush !== 1'b0) begin n_err++; $display("FAIL full_swap: got en=%0b cnt=%0d fl=%0b want 1/1/0", bus.bp_enable, bus.branch_count, bus.flush); end
    #1;
    n_cmp++; if (bus.push_ready !== 1'b0) begin n_err++; $display("FAIL full_still_full: got %0b want 0", bus.push_ready); end
    resolve(1'b1, 32'h0);   // head 0x20, pred 1: correct
    n_cmp++; if (bus.redirect_valid !== 1'b0 || bus.branch_count !== CNT_W'(2)) begin n_err++; $display("FAIL full_drain1: got rv=%0b cnt=%0d want 0/2", bus.redirect_valid, bus.branch_count); end
    resolve(1'b0, 32'h0);   // head 0x44, pred 1: mispredict
    n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h44) begin n_err++; $display("FAIL full_drain2: got %0b/%h want 1/00000044", bus.redirect_valid, bus.redirect_pc); end
    tick();
    tick();
  endtask

  task automatic test_mispredict_with_push();
    apply_reset(2);
    push_br(1'b0, 32'h50);
    push_br(1'b1, 32'h60);
    set_push(1'b1, 32'h70);
    set_resolve(1'b1, 32'h200);
    tick();
    idle();
    n_cmp++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200 || bus.flush !== 1'b1) begin n_err++; $display("FAIL mwp_redirect: got rv=%0b pc=%h fl=%0b want 1/00000200/1", bus.redirect_valid, bus.redirect_pc, bus.flush); end
    set_resolve(1'b0, 32'h0);  // ignored during flush
    tick();
    idle();
    n_cmp++; if (bus.protocol_err !== 1'b0 || bus.bp_enable !== 1'b0 || bus.flush !== 1'b1) begin n_err++; $display("FAIL mwp_flush_ignore: got perr=%0b en=%0b fl=%0b want 0/0/1", bus.protocol_err, bus.bp_enable, bus.flush); end
    tick();
    n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL mwp_flush_end: got %0b want 0", bus.flush); end
    resolve(1'b0, 32'h0);      // queue must be empty
    n_cmp++; if (bus.protocol_err !== 1'b1 || bus.bp_enable !== 1'b0 || bus.branch_count !== CNT_W'(1)) begin n_err++; $display("FAIL mwp_perr: got perr=%0b en=%0b cnt=%0d want 1/0/1", bus.protocol_err, bus.bp_enable, bus.branch_count); end
    tick();
    n_cmp++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL mwp_perr_sticky: got %0b want 1", bus.protocol_err); end
  endtask

  task automatic test_saturation_and_reset_in_flush();
    apply_reset(2);
    push_br(1'b1, 32'h0);
    set_push(1'b1, 32'h0);
    set_resolve(1'b1, 32'h0);
    repeat (MAXC) tick();
    n_cmp++; if (bus.branch_count !== CNT_W'(MAXC)) begin n_err++; $display("FAIL sat_reach: got %h want %h", bus.branch_count, CNT_W'(MAXC)); end
    tick();
    n_cmp++; if (bus.branch_count !== CNT_W'(MAXC) || bus.bp_enable !== 1'b1) begin n_err++; $display("FAIL sat_hold: got %h/%0b want %h/1", bus.branch_count, bus.bp_enable, CNT_W'(MAXC)); end
    idle();
    resolve(1'b0, 32'h0);  // one entry left, pred 1: mispredict
    n_cmp++; if (bus.flush !== 1'b1 || bus.mispredict_count !== CNT_W'(1)) begin n_err++; $display("FAIL sat_misp: got fl=%0b mc=%0d want 1/1", bus.flush, bus.mispredict_count); end
    Reset = 1'b1;
    tick();
    n_cmp++; if (bus.flush !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.branch_count !== '0) begin n_err++; $display("FAIL reset_in_flush: got fl=%0b rv=%0b cnt=%0d want 0/0/0", bus.flush, bus.redirect_valid, bus.branch_count); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (bus.push_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_flush_ready: got %0b want 1", bus.push_ready); end
  endtask

  task automatic test_random();
    logic [PC_W:0] exp_q[$];   // {prediction, pc_plus4}, oldest first
    int          flush_left;
    int unsigned b_cnt, m_cnt;
    logic        perr;
    logic        e_en, e_rv, e_ready;
    logic [1:0]  e_out;
    logic [PC_W-1:0] e_rpc;
    apply_reset(2);
    exp_q.delete();
    flush_left = 0; b_cnt = 0; m_cnt = 0; perr = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic in_run, is_br, do_pop, mis, do_push;
      logic [PC_W:0] head;
      int sz;
      sz = exp_q.size();
      bus.if_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       bus.if_opcode = OPC_JAL;
        1:       bus.if_opcode = OPC_JALR;
        2:       bus.if_opcode = 7'($urandom);
        default: bus.if_opcode = OPC_BR;
      endcase
      bus.if_prediction = 1'($urandom);
      bus.if_pc_plus4   = $urandom;
      bus.stall         = ($urandom_range(0, 4) == 0);
      bus.ex_resolve    = (sz > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);
      bus.ex_taken      = 1'($urandom);
      bus.ex_target     = $urandom;

      in_run  = (flush_left == 0);
      e_ready = in_run && ((sz < DEPTH) || bus.ex_resolve);
      #1;
      n_cmp++; if (bus.push_ready !== e_ready) begin n_err++; $display("FAIL rnd_push_ready[%0d]: got %0b want %0b", cyc, bus.push_ready, e_ready); end

      is_br  = bus.if_valid && (bus.if_opcode == OPC_BR);
      do_pop = in_run && bus.ex_resolve && (sz > 0);
      e_en = 1'b0; e_out = 2'b00; e_rv = 1'b0; e_rpc = '0; mis = 1'b0;
      if (in_run && bus.ex_resolve && sz == 0) perr = 1'b1;
      if (do_pop) begin
        head  = exp_q.pop_front();
        e_en  = 1'b1;
        e_out = bus.ex_taken ? 2'b10 : 2'b01;
        if (b_cnt < MAXC) b_cnt++;
        if (head[PC_W] != bus.ex_taken) begin
          mis   = 1'b1;
          e_rv  = 1'b1;
          e_rpc = bus.ex_taken ? bus.ex_target : head[PC_W-1:0];
          if (m_cnt < MAXC) m_cnt++;
          exp_q.delete();
        end
      end
      do_push = in_run && is_br && !bus.stall && !mis && ((sz < DEPTH) || do_pop);
      if (do_push) exp_q.push_back({bus.if_prediction, bus.if_pc_plus4});
      if (flush_left > 0) flush_left--;
      else if (mis) flush_left = FLUSH_CYC;

      tick();
      n_cmp++; if (bus.bp_enable !== e_en || bus.bp_outcome !== e_out) begin n_err++; $display("FAIL rnd_update[%0d]: got %0b/%b want %0b/%b", cyc, bus.bp_enable, bus.bp_outcome, e_en, e_out); end
      n_cmp++; if (bus.redirect_valid !== e_rv || bus.redirect_pc !== e_rpc) begin n_err++; $display("FAIL rnd_redirect[%0d]: got %0b/%h want %0b/%h", cyc, bus.redirect_valid, bus.redirect_pc, e_rv, e_rpc); end
      n_cmp++; if (bus.flush !== (flush_left > 0)) begin n_err++; $display("FAIL rnd_flush[%0d]: got %0b want %0b", cyc, bus.flush, (flush_left > 0)); end
      n_cmp++; if (bus.branch_count !== CNT_W'(b_cnt) || bus.mispredict_count !== CNT_W'(m_cnt)) begin n_err++; $display("FAIL rnd_counts[%0d]: got %0d/%0d want %0d/%0d", cyc, bus.branch_count, bus.mispredict_count, b_cnt, m_cnt); end
      n_cmp++; if (bus.protocol_err !== perr) begin n_err++; $display("FAIL rnd_perr[%0d]: got %0b want %0b", cyc, bus.protocol_err, perr); end
    end
    idle();
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    idle();
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_full();
    test_mispredict_with_push();
    test_saturation_and_reset_in_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the 2-bit branch predictor in the 5-stage RISC-V pipeline.
- Records each conditional-branch prediction made at IF in an in-order in-flight queue. Retires entries when EX resolves the branch.
- Drives the predictor update (enable + outcome), raises pipeline flush and PC redirect on mispredict, and keeps saturating statistics counters.

Parameters:
- PC_W, 32, PC / target width.
- DEPTH, 2, max unresolved in-flight branches (power of 2, ≥2).
- FLUSH_CYC, 2, cycles flush is held after a mispredict (kills IF/ID and ID/EX).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- if_valid  in  1  valid instruction fetched this cycle.
- if_opcode  in  7  opcode of fetched instruction.
- if_prediction  in  1  predictor output for this fetch (1 = taken).
- if_pc_plus4  in  PC_W  fall-through PC of fetched instruction.
- stall  in  1  pipeline stall; no push while high.
- push_ready  out  1  queue can accept a branch; low forces an IF stall upstream.
- ex_resolve  in  1  EX stage resolves the oldest in-flight branch this cycle.
- ex_taken  in  1  actual direction.
- ex_target  in  PC_W  actual taken target.
- bp_enable  out  1  one-cycle predictor update strobe (gates predictor clock); registered.
- bp_outcome  out  2  update value: 2'b10 taken, 2'b01 not taken, 2'b00 no update.
- flush  out  1  squash younger instructions.
- redirect_valid  out  1  one-cycle PC redirect strobe.
- redirect_pc  out  PC_W  correct-path PC.
- branch_count  out  CNT_W  resolved branches, saturating.
- mispredict_count  out  CNT_W  mispredicts, saturating.
- protocol_err  out  1  sticky: ex_resolve seen with empty queue.

Behaviour:
- Reset:
  - Queue empty, state RUN.
  - Counters 0.
  - All outputs 0 except push_ready = 1.
  - Reset mid-flush aborts the flush immediately.
- Branch detection: `if_valid && if_opcode == 7'b1100011`. JAL/JALR are never queued.
- Push:
  - Occurs on a detected branch with !stall, state RUN, and queue not full (or full with same-cycle pop).
  - Stores {if_prediction, if_pc_plus4} at the tail.
- push_ready = !full || ex_resolve (combinational), forced 0 in FLUSH.
- Pop: on ex_resolve with a non-empty queue; the head entry is compared against ex_taken.
  - Correct: prediction == ex_taken.
  - Mispredict: prediction != ex_taken.
- Predictor update:
  - In the cycle after every valid pop, bp_enable = 1 and bp_outcome = ex_taken ? 2'b10 : 2'b01.
  - Otherwise bp_enable = 0 and bp_outcome = 2'b00.
  - Latency is exactly 1 cycle.
- Mispredict, cycle after the pop:
  - redirect_valid = 1 for 1 cycle.
  - redirect_pc = ex_taken ? ex_target : stored pc_plus4.
  - flush = 1.
  - Queue cleared, since all younger entries are wrong-path.
  - State goes to FLUSH.
- FSM:
  - RUN → FLUSH on mispredict.
  - FLUSH holds flush = 1 for FLUSH_CYC cycles total, counted from the redirect cycle. Then → RUN.
  - In FLUSH, pushes and ex_resolve are ignored; ex_resolve there does not set protocol_err.
- Simultaneous events:
  - Push and mispredict-pop in the same cycle: the push is discarded.
  - Push and correct pop when full: both take effect and occupancy is unchanged.
- Empty queue + ex_resolve in RUN: protocol_err set (sticky until Reset), no update, no counter change.
- Counters:
  - branch_count increments per valid pop; mispredict_count per mispredict.
  - Both saturate at 2^CNT_W − 1 with no wrap.
- Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, push_ready = 1, counters 0.
- Push 1 branch (pred = 1), then ex_resolve with ex_taken = 1 → next cycle bp_enable = 1, bp_outcome = 2'b10, flush = 0, branch_count = 1.
- Push branch (pred = 1, pc_plus4 = 0x104), resolve ex_taken = 0 → next cycle redirect_valid = 1, redirect_pc = 0x104, flush high for exactly 2 cycles, bp_outcome = 2'b01, mispredict_count = 1.
- Fill the queue (2 pushes):
  - push_ready = 0 and a third push is dropped.
  - Then a same-cycle push + correct pop is accepted and occupancy stays 2.
- Push 2 branches; the oldest mispredicts (pred = 0, ex_taken = 1, ex_target = 0x200) together with a new push → redirect_pc = 0x200, the queue is empty after the flush, and a later ex_resolve sets protocol_err.
- Preload branch_count = 0xFFFF via repeated resolves → a further resolve keeps 0xFFFF. Reset asserted during FLUSH → flush = 0 on the next cycle.
